// File: rtl/io_in_debounce.sv
// io_in_debounce: synchronise and debounce io_in[7:2] into clean levels plus edge pulses;
// fall pulses are produced only when IO_IN_DEBOUNCE_FALL_EN is defined.
module io_in_debounce #(
    parameter int WIDTH       = 6,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] db_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);
    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [CNT_W-1:0] cnt [WIDTH];
    logic [WIDTH-1:0] s, mis, hit;
    always_comb begin
        s = sync_q[SYNC_STAGES-1];
        mis = s ^ db_out;
        hit = '0;
        for (int i = 0; i < WIDTH; i++) hit[i] = mis[i] && cnt[i] == CNT_MAX;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
            db_out  <= '0;
            rise    <= '0;
            changed <= 1'b0;
        end else begin
            sync_q[0] <= raw_in;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            for (int i = 0; i < WIDTH; i++) cnt[i] <= (mis[i] && !hit[i]) ? cnt[i] + 1'b1 : '0;
            db_out <= db_out ^ hit;
            rise   <= hit & s;
`ifdef IO_IN_DEBOUNCE_FALL_EN
            changed <= |hit;
`else
            changed <= |(hit & s);
`endif
        end
    end
`ifdef IO_IN_DEBOUNCE_FALL_EN
    always_ff @(posedge clk) fall <= reset ? '0 : hit & ~s;
`else
    assign fall = '0;
`endif
endmodule

// File: tb/tb_io_in_debounce.sv
// tb_io_in_debounce: directed checks of reset, latency, glitch rejection, toggling, multi-bit and mid-run reset.
module tb_io_in_debounce;
`ifdef IO_IN_DEBOUNCE_FALL_EN
    localparam bit FALL_EN = 1'b1;
`else
    localparam bit FALL_EN = 1'b0;
`endif
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] raw_in = '0;
    logic [5:0] db_out, rise, fall;
    logic       changed;
    int nvec = 0;
    int nfail = 0;

    io_in_debounce dut (
        .clk(clk), .reset(reset), .raw_in(raw_in),
        .db_out(db_out), .rise(rise), .fall(fall), .changed(changed)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input logic [5:0] v);
        raw_in = v;
        repeat (10) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        raw_in = 6'b101010;
        repeat (3) tick();
        nvec++;
        if ({db_out, rise, fall, changed} !== 19'd0) begin
            $display("FAIL reset_state: got db=%b rise=%b fall=%b chg=%b, want all 0", db_out, rise, fall, changed);
            nfail++;
        end
        reset = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            tick();
            nvec++;
            if (db_out !== (n >= 6 ? 6'b101010 : 6'b0) || rise !== (n == 6 ? 6'b101010 : 6'b0) ||
                changed !== (n == 6) || fall !== 6'b0) begin
                $display("FAIL reset_release edge %0d: got db=%b rise=%b fall=%b chg=%b", n, db_out, rise, fall, changed);
                nfail++;
            end
        end
        settle(6'b0);
        nvec++;
        if (db_out !== 6'b0) begin
            $display("FAIL settle_zero: got db=%b, want 000000", db_out);
            nfail++;
        end
    endtask

    task automatic test_glitch();
        raw_in = 6'b000001;
        for (int n = 1; n <= 12; n++) begin
            tick();
            if (n == 3) raw_in = 6'b0;
            nvec++;
            if (db_out !== 6'b0 || rise !== 6'b0 || changed !== 1'b0) begin
                $display("FAIL glitch edge %0d: got db=%b rise=%b chg=%b, want 0", n, db_out, rise, changed);
                nfail++;
            end
        end
    endtask

    task automatic test_pulse();
        logic [5:0] edb, ef;
        raw_in = 6'b000001;
        for (int n = 1; n <= 14; n++) begin
            tick();
            if (n == 4) raw_in = 6'b0;
            edb = (n >= 6 && n <= 9) ? 6'b000001 : 6'b0;
            ef = (FALL_EN && n == 10) ? 6'b000001 : 6'b0;
            nvec++;
            if (db_out !== edb || rise !== (n == 6 ? 6'b000001 : 6'b0) || fall !== ef ||
                changed !== (n == 6 || (FALL_EN && n == 10))) begin
                $display("FAIL pulse edge %0d: got db=%b rise=%b fall=%b chg=%b, want db=%b fall=%b",
                         n, db_out, rise, fall, changed, edb, ef);
                nfail++;
            end
        end
    endtask

    task automatic test_toggle();
        for (int n = 1; n <= 20; n++) begin
            raw_in = (n > 10 || n % 2 == 1) ? 6'b001000 : 6'b0;
            tick();
            nvec++;
            if (rise !== (n == 16 ? 6'b001000 : 6'b0) || db_out !== (n >= 16 ? 6'b001000 : 6'b0) ||
                changed !== (n == 16) || fall !== 6'b0) begin
                $display("FAIL toggle edge %0d: got db=%b rise=%b fall=%b chg=%b", n, db_out, rise, fall, changed);
                nfail++;
            end
        end
        settle(6'b0);
    endtask

    task automatic test_simultaneous();
        int nchg;
        nchg = 0;
        raw_in = 6'b100001;
        for (int n = 1; n <= 9; n++) begin
            tick();
            nchg += int'(changed);
            nvec++;
            if (rise !== (n == 6 ? 6'b100001 : 6'b0)) begin
                $display("FAIL simul_rise edge %0d: got %b, want %b", n, rise, n == 6 ? 6'b100001 : 6'b0);
                nfail++;
            end
        end
        nvec++;
        if (nchg != 1) begin
            $display("FAIL simul_changed_count: got %0d, want 1", nchg);
            nfail++;
        end
        settle(6'b0);
    endtask

    task automatic test_reset_mid();
        raw_in = 6'b000100;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        nvec++;
        if ({db_out, rise, fall, changed} !== 19'd0) begin
            $display("FAIL reset_mid_state: got db=%b rise=%b fall=%b chg=%b, want all 0", db_out, rise, fall, changed);
            nfail++;
        end
        reset = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            tick();
            nvec++;
            if (rise !== (n == 6 ? 6'b000100 : 6'b0) || db_out !== (n >= 6 ? 6'b000100 : 6'b0)) begin
                $display("FAIL reset_mid edge %0d: got db=%b rise=%b", n, db_out, rise);
                nfail++;
            end
        end
        settle(6'b0);
    endtask

    task automatic test_fall();
        settle(6'b000010);
        raw_in = 6'b0;
        for (int n = 1; n <= 8; n++) begin
            tick();
            nvec++;
            if (db_out !== (n >= 6 ? 6'b0 : 6'b000010) || rise !== 6'b0 ||
                fall !== ((FALL_EN && n == 6) ? 6'b000010 : 6'b0) || changed !== (FALL_EN && n == 6)) begin
                $display("FAIL fall edge %0d: got db=%b rise=%b fall=%b chg=%b", n, db_out, rise, fall, changed);
                nfail++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_pulse();
        test_toggle();
        test_simultaneous();
        test_reset_mid();
        test_fall();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
